// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet launch path (fire controller and bullet block).
package bullet_pkg;

  localparam int COORD_W = 10;

  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_IN_FLIGHT = 3'd3,
    ST_COOLDOWN  = 3'd4
  } fire_state_t;

  // The bullet block only understands left/right/up; the unused code faces right.
  function automatic logic [1:0] map_dir(input logic [1:0] d);
    return (d == 2'b11) ? DIR_RIGHT : d;
  endfunction

endpackage

// File: rtl/bullet_fire_ctrl_if.sv
// Launch handshake between the fire controller (master) and the bullet block (slave).
interface bullet_fire_ctrl_if
  import bullet_pkg::*;
();

  logic               launch;
  logic [COORD_W-1:0] start_x;
  logic [COORD_W-1:0] start_y;
  logic [1:0]         dir;
  logic               bullet_state;

  modport master (output launch, start_x, start_y, dir, input bullet_state);
  modport slave  (input launch, start_x, start_y, dir, output bullet_state);

endinterface

// File: rtl/frame_tick_gen.sv
// Turns the ~60 Hz frame strobe into a registered one-Clk-wide tick on its rising edge.
module frame_tick_gen (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);

  logic frame_d_q;
  logic frame_tick_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_d_q    <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      frame_d_q    <= frame_clk;
      frame_tick_q <= frame_clk & ~frame_d_q;
    end
  end

  assign frame_tick = frame_tick_q;

endmodule

// File: rtl/bullet_fire_ctrl.sv
// Fire-key to bullet-launch controller: edge-detected fire, ack tracking, cooldown and ammo reload.
module bullet_fire_ctrl
  import bullet_pkg::*;
#(
  parameter int MAX_AMMO        = 5,
  parameter int AMMO_W          = 4,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int RELOAD_FRAMES   = 60,
  parameter int ACK_TIMEOUT     = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               fire_key,
  input  logic [COORD_W-1:0] tank_x,
  input  logic [COORD_W-1:0] tank_y,
  input  logic [1:0]         tank_dir,
  bullet_fire_ctrl_if.master bus,
  output logic [AMMO_W-1:0]  ammo,
  output logic               ready,
  output logic               fire_err
);

  localparam int CD_W = $clog2(COOLDOWN_FRAMES) + 1;
  localparam int RL_W = $clog2(RELOAD_FRAMES) + 1;
  localparam int AK_W = $clog2(ACK_TIMEOUT) + 1;

  fire_state_t        state_q, state_d;
  logic               fire_key_d_q;
  logic [AK_W-1:0]    ack_cnt_q, ack_cnt_d;
  logic [CD_W-1:0]    cd_cnt_q, cd_cnt_d;
  logic [RL_W-1:0]    rl_cnt_q, rl_cnt_d;
  logic [AMMO_W-1:0]  ammo_q, ammo_d;
  logic [COORD_W-1:0] start_x_q, start_x_d;
  logic [COORD_W-1:0] start_y_q, start_y_d;
  logic [1:0]         dir_q, dir_d;
  logic               launch_q;
  logic               ready_q, ready_d;
  logic               fire_err_q, fire_err_d;
  logic               frame_tick;
  logic               fire_req;
  logic               take;
  logic               give;

  frame_tick_gen u_frame_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (frame_tick)
  );

  assign fire_req = fire_key & ~fire_key_d_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    ack_cnt_d  = '0;
    cd_cnt_d   = cd_cnt_q;
    start_x_d  = start_x_q;
    start_y_d  = start_y_q;
    dir_d      = dir_q;
    fire_err_d = 1'b0;
    take       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fire_req && (ammo_q != '0) && !bus.bullet_state) begin
          take      = 1'b1;
          state_d   = ST_LAUNCH;
          start_x_d = tank_x;
          start_y_d = tank_y;
          dir_d     = map_dir(tank_dir);
        end
      end
      ST_LAUNCH: state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (bus.bullet_state) begin
          state_d = ST_IN_FLIGHT;
        end else if (ack_cnt_q == AK_W'(ACK_TIMEOUT - 1)) begin
          state_d    = ST_COOLDOWN;
          cd_cnt_d   = CD_W'(COOLDOWN_FRAMES);
          fire_err_d = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + AK_W'(1);
        end
      end
      ST_IN_FLIGHT: begin
        if (!bus.bullet_state) begin
          state_d  = ST_COOLDOWN;
          cd_cnt_d = CD_W'(COOLDOWN_FRAMES);
        end
      end
      ST_COOLDOWN: begin
        if (cd_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else if (frame_tick) begin
          cd_cnt_d = cd_cnt_q - CD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload runs independently of the FSM; a simultaneous +1 and -1 cancel out.
  always_comb begin
    rl_cnt_d = rl_cnt_q;
    give     = 1'b0;
    if (ammo_q >= AMMO_W'(MAX_AMMO)) begin
      rl_cnt_d = '0;
    end else if (frame_tick) begin
      if (rl_cnt_q == RL_W'(RELOAD_FRAMES - 1)) begin
        rl_cnt_d = '0;
        give     = 1'b1;
      end else begin
        rl_cnt_d = rl_cnt_q + RL_W'(1);
      end
    end

    case ({give, take})
      2'b10:   ammo_d = ammo_q + AMMO_W'(1);
      2'b01:   ammo_d = ammo_q - AMMO_W'(1);
      default: ammo_d = ammo_q;
    endcase

    ready_d = (state_d == ST_IDLE) && (ammo_d != '0) && !bus.bullet_state;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      fire_key_d_q <= 1'b0;
      ack_cnt_q    <= '0;
      cd_cnt_q     <= '0;
      rl_cnt_q     <= '0;
      ammo_q       <= AMMO_W'(MAX_AMMO);
      start_x_q    <= '0;
      start_y_q    <= '0;
      dir_q        <= DIR_UP;
      launch_q     <= 1'b0;
      ready_q      <= 1'b0;
      fire_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fire_key_d_q <= fire_key;
      ack_cnt_q    <= ack_cnt_d;
      cd_cnt_q     <= cd_cnt_d;
      rl_cnt_q     <= rl_cnt_d;
      ammo_q       <= ammo_d;
      start_x_q    <= start_x_d;
      start_y_q    <= start_y_d;
      dir_q        <= dir_d;
      launch_q     <= (state_d == ST_LAUNCH);
      ready_q      <= ready_d;
      fire_err_q   <= fire_err_d;
    end
  end

  assign bus.launch  = launch_q;
  assign bus.start_x = start_x_q;
  assign bus.start_y = start_y_q;
  assign bus.dir     = dir_q;
  assign ammo        = ammo_q;
  assign ready       = ready_q;
  assign fire_err    = fire_err_q;

endmodule

// File: tb/tb_bullet_fire_ctrl.sv
// Directed bench: unit A uses the default 15-frame cooldown, unit B has no cooldown.
module tb_bullet_fire_ctrl;

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic [1:0] fire_key;
  logic [9:0] tank_x;
  logic [9:0] tank_y;
  logic [1:0] tank_dir;
  logic [3:0] ammo_a, ammo_b;
  logic       ready_a, ready_b;
  logic       fire_err_a, fire_err_b;

  int n_checks = 0;
  int n_pass   = 0;

  bullet_fire_ctrl_if bif_a ();
  bullet_fire_ctrl_if bif_b ();

  bullet_fire_ctrl dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire_key(fire_key[0]),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .bus(bif_a),
    .ammo(ammo_a), .ready(ready_a), .fire_err(fire_err_a)
  );

  bullet_fire_ctrl #(.COOLDOWN_FRAMES(0)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire_key(fire_key[1]),
    .tank_x(tank_x), .tank_y(tank_y), .tank_dir(tank_dir), .bus(bif_b),
    .ammo(ammo_b), .ready(ready_b), .fire_err(fire_err_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One frame tick, fully consumed by the DUTs before returning.
  task automatic tick();
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic launch_of(input int u);
    return (u == 1) ? bif_b.launch : bif_a.launch;
  endfunction

  task automatic set_bs(input int u, input logic v);
    if (u == 1) bif_b.bullet_state = v;
    else        bif_a.bullet_state = v;
  endtask

  // Fresh key press on unit u; counts launch pulses seen over the next cycles.
  task automatic press_count(input int u, input int cycles, output int cnt);
    fire_key[u] = 1'b1;
    cnt = 0;
    repeat (cycles) begin
      step(1);
      if (launch_of(u)) cnt++;
    end
    fire_key[u] = 1'b0;
  endtask

  // Full shot on unit B: launch, bullet acks, bullet ends, back to IDLE.
  task automatic fire_b(input string tag);
    int c;
    press_count(1, 1, c);
    check(tag, c, 1);
    set_bs(1, 1'b1);
    step(2);
    set_bs(1, 1'b0);
    step(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, cnt, first;

    Reset = 1'b1; frame_clk = 1'b0; fire_key = 2'b00;
    tank_x = '0; tank_y = '0; tank_dir = 2'b00;
    bif_a.bullet_state = 1'b0;
    bif_b.bullet_state = 1'b0;
    step(3);
    check("rst_launch",  bif_a.launch,  0);
    check("rst_start_x", bif_a.start_x, 0);
    check("rst_start_y", bif_a.start_y, 0);
    check("rst_dir",     bif_a.dir,     2);
    check("rst_ammo",    ammo_a,        5);
    check("rst_ready",   ready_a,       0);
    check("rst_fire_err", fire_err_a,   0);
    check("rst_ammo_b",  ammo_b,        5);
    Reset = 1'b0;
    step(2);
    check("ready_after_rst", ready_a, 1);

    // First shot: accepted on the edge that sees the key rise, launch the cycle after.
    tank_x = 10'd100; tank_y = 10'd200; tank_dir = 2'b10;
    fire_key[0] = 1'b1;
    step(1);
    check("launch_hi",    bif_a.launch,  1);
    check("start_x",      bif_a.start_x, 100);
    check("start_y",      bif_a.start_y, 200);
    check("dir_up",       bif_a.dir,     2);
    check("ammo_dec",     ammo_a,        4);
    check("ready_busy",   ready_a,       0);
    step(1);
    check("launch_1cyc",  bif_a.launch,  0);

    // Key stays held for 1000 cycles while the bullet lives and ends; ticks every 6 cycles.
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0)     set_bs(0, 1'b1);
      if (i == 20)    set_bs(0, 1'b0);
      if (i % 6 == 0) frame_clk = 1'b1;
      if (i % 6 == 3) frame_clk = 1'b0;
      step(1);
      if (bif_a.launch) cnt++;
    end
    check("held_extra_launch", cnt, 0);
    fire_key[0] = 1'b0;
    frame_clk = 1'b0;
    step(2);
    check("held_ammo_reload", ammo_a, 5);
    check("held_ready_idle",  ready_a, 1);

    // Flight of 30 frames, then 15-frame cooldown; presses inside are dropped.
    press_count(0, 2, c);
    check("flight_launch", c, 1);
    check("flight_ammo",   ammo_a, 4);
    set_bs(0, 1'b1);
    ticks(30);
    press_count(0, 4, c);
    check("flight_press",  c, 0);
    set_bs(0, 1'b0);
    step(1);
    ticks(7);
    press_count(0, 4, c);
    check("cooldown_press", c, 0);
    ticks(7);
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    step(1);
    check("cd_zero_not_ready", ready_a, 0);
    step(1);
    check("first_idle_ready", ready_a, 1);
    press_count(0, 2, c);
    check("first_idle_launch", c, 1);
    check("first_idle_ammo", ammo_a, 3);

    // No ack: 8 WAIT_ACK cycles after the launch cycle, fire_err in the 9th.
    cnt = 0; first = 0;
    for (int k = 2; k <= 20; k++) begin
      step(1);
      if (fire_err_a) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    check("timeout_delay", first, 9);
    check("timeout_pulses", cnt, 1);
    check("timeout_no_refund", ammo_a, 3);
    // 45 reload ticks so far at ammo<5; 15 more completes the 60-tick reload.
    ticks(15);
    step(2);
    check("timeout_cd_ready", ready_a, 1);
    check("reload_during_cd", ammo_a, 4);

    // Direction 11 maps to right; async reset while in flight.
    tank_x = 10'd7; tank_y = 10'd9; tank_dir = 2'b11;
    press_count(0, 1, c);
    check("dir11_launch", c, 1);
    check("dir11_mapped", bif_a.dir, 1);
    check("dir11_start_x", bif_a.start_x, 7);
    check("dir11_ammo", ammo_a, 3);
    set_bs(0, 1'b1);
    step(3);
    #2 Reset = 1'b1;
    #1;
    check("async_rst_ammo",   ammo_a,        5);
    check("async_rst_launch", bif_a.launch,  0);
    check("async_rst_dir",    bif_a.dir,     2);
    check("async_rst_x",      bif_a.start_x, 0);
    @(negedge Clk);
    Reset = 1'b0;
    step(1);
    press_count(0, 4, c);
    check("live_bullet_blocks", c, 0);
    check("live_bullet_ready",  ready_a, 0);
    set_bs(0, 1'b0);
    step(2);
    check("bullet_gone_ready", ready_a, 1);
    press_count(0, 1, c);
    check("bullet_gone_launch", c, 1);
    set_bs(0, 1'b1);
    step(2);
    set_bs(0, 1'b0);

    // Unit B: reload/launch collision, emptying the magazine, reload saturation.
    fire_b("b_shot1");
    ticks(59);
    check("b_pre_align_ammo", ammo_b, 4);
    fire_b("b_shot2");
    check("b_ammo3", ammo_b, 3);
    frame_clk = 1'b1;
    step(1);
    frame_clk = 1'b0;
    fire_key[1] = 1'b1;
    step(1);
    check("b_align_launch", bif_b.launch, 1);
    check("b_align_ammo",   ammo_b, 3);
    fire_key[1] = 1'b0;
    set_bs(1, 1'b1);
    step(2);
    set_bs(1, 1'b0);
    step(3);
    fire_b("b_shot4");
    fire_b("b_shot5");
    fire_b("b_shot6");
    check("b_empty_ammo",  ammo_b,  0);
    check("b_empty_ready", ready_b, 0);
    press_count(1, 4, c);
    check("b_empty_press", c, 0);
    ticks(60);
    check("b_reload_one", ammo_b, 1);
    ticks(240);
    check("b_reload_full", ammo_b, 5);
    ticks(5);
    check("b_saturate", ammo_b, 5);
    check("b_full_ready", ready_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
